// File: rtl/seg_display_mux.sv
// Time-multiplexed hex 7-segment driver with frame-synchronous value commit.
// Optional leading-zero blanking is compiled in with `define SEG_DISPLAY_LZ_BLANK_EN.
module seg_display_mux #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 10000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    io_out_en,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_select,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic                    pending_q, pending_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic                    cnt_end;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    dark;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign cnt_end = (cnt_q == CNT_MAX);
  assign wrap    = cnt_end && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d        = cnt_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    frame_tick_d = wrap;

    if (cnt_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    if (wr_en) begin
      shadow_val_d = wr_data;
      shadow_dp_d  = wr_dp;
      pending_d    = 1'b1;
    end
    // A write landing on the wrap cycle bypasses the shadow so it is not delayed a frame.
    if (wrap) begin
      pending_d = 1'b0;
      if (wr_en) begin
        active_val_d = wr_data;
        active_dp_d  = wr_dp;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
    assign sel_onehot[gi] = (idx_q == IDX_W'(gi));
  end

`ifdef SEG_DISPLAY_LZ_BLANK_EN
  logic all_zero;
  always_comb begin
    lz_dark  = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero && (active_val_q[4*k +: 4] == 4'h0);
      lz_dark[k] = all_zero && !active_dp_q[k];
    end
  end
`else
  assign lz_dark = '0;
`endif

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_onehot[k]) begin
        cur_nib = active_val_q[4*k +: 4];
        cur_dp  = active_dp_q[k];
      end
    end
  end

  assign dark = !io_out_en || (|(sel_onehot & (digit_mask | lz_dark)));

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = SEG_ACTIVE_LOW;
    sel_d = DIG_OFF;
    if (!dark) begin
      seg_d = hex_to_seg(cur_nib) ^ {7{SEG_ACTIVE_LOW}};
      dp_d  = cur_dp ^ SEG_ACTIVE_LOW;
      sel_d = sel_onehot ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_ACTIVE_LOW;
      sel_q        <= DIG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
    end
  end

  assign seg_out      = seg_q;
  assign dp_out       = dp_q;
  assign digit_select = sel_q;
  assign frame_tick   = frame_tick_q;

endmodule
